// File: rtl/ch_pkg.sv
// ch_pkg: shared types and the round-robin helper for the multi-channel DMA source buffer.
package ch_pkg;
  typedef enum logic {ST_IDLE, ST_ACTIVE} st_t;
  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } entry_t;
  // First requester after prev, wrapping within n channels; bit 3 flags a hit.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] prev, input int n);
    logic [3:0] r;
    int idx;
    r = '0;
    for (int i = 8; i >= 1; i--) begin
      idx = (int'(prev) + i) % n;
      if (i <= n && req[idx[2:0]]) r = {1'b1, idx[2:0]};
    end
    return r;
  endfunction
endpackage

// File: rtl/ch_sfifo.sv
// ch_sfifo: per-channel word packer, optional byte swap (CH_BSWAP_EN), FWFT FIFO and status flags.
module ch_sfifo
  import ch_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        xfer,
  input  logic        last,
  input  logic [31:0] dat,
  input  logic        bswap,
  input  logic        flush,
  input  logic        pop,
  output entry_t      head,
  output logic        empty,
  output logic [AW:0] cnt,
  output logic        stop,
  output logic        ovf
);
  localparam int DEPTH = 1 << AW;
  entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic hi;
  logic [31:0] lo, w;
  logic wr, wr_ok, do_pop;
  entry_t wd;
  logic [AW:0] cnt_n;
`ifdef CH_BSWAP_EN
  assign w = bswap ? {dat[7:0], dat[15:8], dat[23:16], dat[31:24]} : dat;
`else
  logic unused_bswap;
  assign unused_bswap = bswap;
  assign w = dat;
`endif
  assign wr = xfer && !flush && (hi || last);
  assign wd = {last, hi ? {w, lo} : {32'h0, w}};
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_ok = wr && (!cnt[AW] || do_pop);
  assign cnt_n = cnt + (AW+1)'(wr_ok) - (AW+1)'(do_pop);
  assign head = mem[rp];
  always_ff @(posedge clk) if (wr_ok) mem[wp] <= wd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      hi <= 1'b0;
      lo <= '0;
      stop <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (xfer) hi <= !hi && !last;
      if (xfer && !hi) lo <= w;
      if (wr_ok) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt_n;
      stop <= cnt_n > (AW+1)'(DEPTH - 2);
      ovf <= ovf | (wr && !wr_ok);
    end
  end
endmodule

// File: rtl/chn_src_buf.sv
// chn_src_buf: NCH packing source FIFOs behind a round-robin grant to one memory engine.
// Optional per-channel byte swap is built when CH_BSWAP_EN is defined.
module chn_src_buf
  import ch_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int AW     = 4,
  parameter int AE_THR = 2,
  parameter int CW     = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NCH-1:0]    ss_xfer,
  input  logic [NCH-1:0]    ss_last,
  input  logic [32*NCH-1:0] ss_dat,
  input  logic [NCH-1:0]    ss_bswap,
  input  logic [NCH-1:0]    m_reset,
  output logic [NCH-1:0]    ss_stop,
  output logic [NCH-1:0]    ss_ovf,
  input  logic              m_getn,
  output logic              m_gnt_vld,
  output logic [2:0]        m_gnt_ch,
  output logic [63:0]       m_src,
  output logic              m_src_last,
  output logic              m_src_empty,
  output logic              m_src_almost_empty,
  output logic [CW-1:0]     ocnt
);
  entry_t head [8];
  logic [AW:0] cnt [8];
  logic [7:0] emp, rst8, req;
  logic [3:0] pick;
  logic [2:0] last_q;
  logic pop_ok, done;
  st_t st;
  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_ch
      if (g < NCH) begin : g_on
        ch_sfifo #(.AW(AW)) u_fifo (
          .clk(wb_clk_i), .rst_n(wb_rst_i), .xfer(ss_xfer[g]), .last(ss_last[g]),
          .dat(ss_dat[32*g +: 32]), .bswap(ss_bswap[g]), .flush(m_reset[g]),
          .pop(pop_ok && m_gnt_ch == 3'(g)), .head(head[g]), .empty(emp[g]),
          .cnt(cnt[g]), .stop(ss_stop[g]), .ovf(ss_ovf[g])
        );
      end else begin : g_off
        assign head[g] = '0;
        assign emp[g] = 1'b1;
        assign cnt[g] = '0;
      end
    end
  endgenerate
  assign rst8 = 8'(m_reset);
  // A channel being flushed this cycle must not win, or the grant would sit on an empty FIFO.
  assign req = ~emp & ~rst8;
  assign pick = rr_pick(req, last_q, NCH);
  assign m_gnt_vld = st == ST_ACTIVE;
  assign pop_ok = m_gnt_vld && !m_getn && !emp[m_gnt_ch] && !rst8[m_gnt_ch];
  assign done = rst8[m_gnt_ch] || (pop_ok && head[m_gnt_ch].last);
  assign m_src_empty = !m_gnt_vld || emp[m_gnt_ch];
  assign m_src = m_src_empty ? '0 : head[m_gnt_ch].data;
  assign m_src_last = !m_src_empty && head[m_gnt_ch].last;
  assign m_src_almost_empty = !m_gnt_vld || cnt[m_gnt_ch] <= (AW+1)'(AE_THR);
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      st <= ST_IDLE;
      m_gnt_ch <= '0;
      last_q <= 3'(NCH - 1);
      ocnt <= '0;
    end else if (st == ST_IDLE) begin
      if (pick[3]) begin
        st <= ST_ACTIVE;
        m_gnt_ch <= pick[2:0];
        last_q <= pick[2:0];
        ocnt <= '0;
      end
    end else begin
      if (done) st <= ST_IDLE;
      if (pop_ok && !(&ocnt)) ocnt <= ocnt + 1'b1;
    end
  end
endmodule
